sfifo_rr_ctrl: RTL and testbench

Write-side arbiter and read-side sequencer for the 16-deep x 8-bit synchronous FIFO (iiitb_sfifo).
- Shares the single FIFO write port between NREQ requesters using round-robin arbitration.
- Keeps an authoritative occupancy count, so the FIFO never overflows or underflows.
- Converts the FIFO's one-cycle read latency into a valid/ready output stream.
- Sits between user_proj_example I/O logic and the FIFO instance.

---
 rtl/sfifo_rr_ctrl.sv | 125 ++++++++++++
 tb/tb_sfifo_rr_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_rr_ctrl.sv
// Round-robin write arbiter and valid/ready read sequencer for the 16x8 synchronous FIFO.
// Define SFIFO_CTRL_ALMOST_FULL_EN to add the registered almost_full flag (AF_THRESH).

module sfifo_rr_lane #(
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  assign dout = sel ? din : '0;
endmodule

module sfifo_rr_ctrl #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CW    = 5
`ifdef SFIFO_CTRL_ALMOST_FULL_EN
  ,parameter int AF_THRESH = 12
`endif
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               fifo_write,
  output logic [DW-1:0]      fifo_wdata,
  output logic               fifo_read,
  input  logic [DW-1:0]      fifo_rdata,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  input  logic               out_ready,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
`ifdef SFIFO_CTRL_ALMOST_FULL_EN
  ,output logic              almost_full
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           cand;
  logic [PW-1:0]           win_idx;
  logic                    win_found;
  logic [CW-1:0]           count_nxt;
  logic [NREQ-1:0][DW-1:0] lane_data;

  // Rotating priority: scan from the slot after the last winner, first asserted req wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // No same-cycle bypass at full: a read this cycle frees the slot only next cycle.
  always_comb begin
    gnt = '0;
    if (RSTn && win_found && (count < CW'(DEPTH)))
      gnt[win_idx] = 1'b1;
  end

  assign fifo_write = |gnt;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    sfifo_rr_lane #(.DW(DW)) u_lane (
      .sel  (gnt[g]),
      .din  (wdata[g*DW +: DW]),
      .dout (lane_data[g])
    );
  end

  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NREQ; i++)
      fifo_wdata = fifo_wdata | lane_data[i];
  end

  // count excludes the word parked in the output stage, so a write at count==0 cannot be read yet.
  assign fifo_read = RSTn && (count != '0) && (!out_valid || out_ready);
  assign out_data  = fifo_rdata;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign count_nxt = count + CW'(fifo_write) - CW'(fifo_read);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      count     <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= PW'(NREQ - 1);
    end else begin
      count <= count_nxt;
      if (fifo_read)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
      if (fifo_write)
        rr_ptr <= win_idx;
    end
  end

`ifdef SFIFO_CTRL_ALMOST_FULL_EN
  always_ff @(posedge CLK) begin
    if (!RSTn)
      almost_full <= 1'b0;
    else
      almost_full <= (count_nxt >= CW'(AF_THRESH));
  end
`endif

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge CLK) disable iff (!RSTn) count <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_sfifo_rr_ctrl.sv
// Bench for sfifo_rr_ctrl: behavioural 16x8 FIFO behind the controller, scoreboard on the output stream.
module tb_sfifo_rr_ctrl;
  localparam int NREQ = 4, DW = 8, DEPTH = 16, CW = 5;

  logic               CLK = 1'b0;
  logic               RSTn = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic               out_ready = 1'b0;
  logic [NREQ-1:0]    gnt;
  logic               fifo_write, fifo_read, out_valid, full, empty;
  logic [DW-1:0]      fifo_wdata, out_data;
  logic [DW-1:0]      fifo_rdata;
  logic [CW-1:0]      count;
`ifdef SFIFO_CTRL_ALMOST_FULL_EN
  logic               almost_full;
`endif

  always #5 CLK = ~CLK;

  sfifo_rr_ctrl #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .req        (req),
    .wdata      (wdata),
    .gnt        (gnt),
    .fifo_write (fifo_write),
    .fifo_wdata (fifo_wdata),
    .fifo_read  (fifo_read),
    .fifo_rdata (fifo_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
`ifdef SFIFO_CTRL_ALMOST_FULL_EN
    ,.almost_full (almost_full)
`endif
  );

  // Behavioural FIFO: registered oData, held between reads, reset with the controller.
  logic [DW-1:0] mem [DEPTH];
  int wp = 0, rp = 0;
  always @(posedge CLK) begin
    if (!RSTn) begin
      wp <= 0;
      rp <= 0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_write) begin
        mem[wp % DEPTH] <= fifo_wdata;
        wp <= wp + 1;
      end
      if (fifo_read) begin
        fifo_rdata <= mem[rp % DEPTH];
        rp <= rp + 1;
      end
    end
  end

  logic [DW-1:0] sb[$];
  int n_checks = 0, n_fail = 0, n_pop = 0;

  // Output monitor: samples late in the cycle, before the handshake edge.
  always @(negedge CLK) begin
    logic [DW-1:0] exp_d;
    #3;
    if (RSTn) begin
      if (fifo_write) begin
        n_checks++;
        if ((wp - rp) >= DEPTH) begin
          n_fail++;
          $display("FAIL fifo_overflow: write with %0d words resident, limit %0d", wp - rp, DEPTH);
        end
      end
      if (fifo_read) begin
        n_checks++;
        if (wp == rp) begin
          n_fail++;
          $display("FAIL fifo_underflow: read with 0 words resident, need >0");
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got %02h, expected no word", out_data);
        end else begin
          exp_d = sb.pop_front();
          n_pop++;
          if (out_data !== exp_d) begin
            n_fail++;
            $display("FAIL out_data: got %02h, expected %02h", out_data, exp_d);
          end
        end
      end
    end
  end

  task automatic drain(output int cyc);
    cyc = 0;
    @(negedge CLK);
    req = '0;
    out_ready = 1'b1;
    #1;
    while ((sb.size() != 0 || out_valid) && cyc < 60) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    RSTn = 1'b0; req = '1; out_ready = 1'b0;
    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      n_checks++;
      if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b, expected 0000", gnt); end
    end
    @(negedge CLK);
    RSTn = 1'b1; req = '0;
    #1;
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || fifo_read !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b out_valid=%b fifo_read=%b, expected 0 1 0 0 0",
               count, empty, full, out_valid, fifo_read);
    end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_g;
    logic [DW-1:0]   exp_d;
    out_ready = 1'b0;
    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      req = '1;
      #1;
      exp_g = NREQ'(1 << (i % NREQ));
      exp_d = DW'(8'hA0 + (i % NREQ));
      sb.push_back(exp_d);
      n_checks++;
      if (gnt !== exp_g || fifo_wdata !== exp_d) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: gnt=%b wdata=%02h, expected %b %02h", i, gnt, fifo_wdata, exp_g, exp_d);
      end
    end
    @(negedge CLK);
    req = '0;
    #1;
    // 8 accepted: 7 resident plus the one parked in the output stage
    n_checks++;
    if (count !== 5'd7 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_count: count=%0d out_valid=%b, expected 7 1", count, out_valid);
    end
  endtask

  task automatic test_output_order;
    int p0, cyc;
    p0 = n_pop;
    drain(cyc);
    n_checks++;
    if (cyc >= 60 || (n_pop - p0) != 8 || count !== 5'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL order_drain: cycles=%0d popped=%0d count=%0d, expected <60 8 0", cyc, n_pop - p0, count);
    end
  endtask

  task automatic test_fill_full;
    logic [NREQ-1:0] exp_g;
    int cyc;
    out_ready = 1'b0;
    // DEPTH words fit in the FIFO plus one in the output stage
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      req = 4'b0100;
      wdata[2*DW +: DW] = DW'(8'h10 + i);
      #1;
      exp_g = (i < DEPTH + 1) ? 4'b0100 : 4'b0000;
      if (i < DEPTH + 1) sb.push_back(DW'(8'h10 + i));
      n_checks++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL fill_gnt[%0d]: got %b, expected %b", i, gnt, exp_g); end
    end
    n_checks++;
    if (count !== 5'd16 || full !== 1'b1 || empty !== 1'b0 || out_valid !== 1'b1 || fifo_read !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: count=%0d full=%b empty=%b out_valid=%b fifo_read=%b, expected 16 1 0 1 0",
               count, full, empty, out_valid, fifo_read);
    end
`ifdef SFIFO_CTRL_ALMOST_FULL_EN
    n_checks++;
    if (almost_full !== 1'b1) begin n_fail++; $display("FAIL almost_full: got %b, expected 1", almost_full); end
`endif
    @(negedge CLK);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (fifo_read !== 1'b1 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL full_read: fifo_read=%b gnt=%b, expected 1 0000", fifo_read, gnt);
    end
    @(negedge CLK);
    out_ready = 1'b0;
    req = '1;
    wdata[3*DW +: DW] = 8'h3D;
    #1;
    sb.push_back(8'h3D);
    n_checks++;
    if (count !== 5'd15 || full !== 1'b0 || gnt !== 4'b1000 || fifo_wdata !== 8'h3D) begin
      n_fail++;
      $display("FAIL full_resume: count=%0d gnt=%b wdata=%02h, expected 15 1000 3d", count, gnt, fifo_wdata);
    end
    drain(cyc);
    n_checks++;
    if (cyc >= 60 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL full_drain: cycles=%0d count=%0d, expected <60 0", cyc, count);
    end
  endtask

  task automatic test_latency;
    @(negedge CLK);
    out_ready = 1'b0;
    req = 4'b0001;
    wdata[0 +: DW] = 8'h5C;
    #1;
    sb.push_back(8'h5C);
    n_checks++;
    if (gnt !== 4'b0001 || fifo_read !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_write: gnt=%b fifo_read=%b, expected 0001 0", gnt, fifo_read);
    end
    @(negedge CLK);
    req = '0;
    #1;
    n_checks++;
    if (fifo_read !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_read: fifo_read=%b out_valid=%b, expected 1 0", fifo_read, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h5C || fifo_read !== 1'b0) begin
        n_fail++;
        $display("FAIL lat_hold[%0d]: out_valid=%b out_data=%02h fifo_read=%b, expected 1 5c 0",
                 i, out_valid, out_data, fifo_read);
      end
    end
    @(negedge CLK);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL lat_accept: out_valid=%b pending=%0d, expected 0 0", out_valid, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int p0, cyc;
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      req = 4'b0010;
      wdata[DW +: DW] = DW'(8'h60 + i);
      out_ready = (i >= 8);
      #1;
      sb.push_back(DW'(8'h60 + i));
      n_checks++;
      if (gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b, expected 0010", i, gnt); end
      if (i >= 8) begin
        n_checks++;
        if (count !== 5'd7 || out_valid !== 1'b1 || fifo_read !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_stream[%0d]: count=%0d out_valid=%b fifo_read=%b, expected 7 1 1",
                   i, count, out_valid, fifo_read);
        end
      end
    end
    @(negedge CLK);
    RSTn = 1'b0;
    req = '0;
    sb.delete();
    @(negedge CLK);
    RSTn = 1'b1;
    req = '1;
    out_ready = 1'b0;
    wdata[0 +: DW] = 8'h77;
    #1;
    sb.push_back(8'h77);
    n_checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || empty !== 1'b1 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset: count=%0d out_valid=%b empty=%b gnt=%b, expected 0 0 1 0001",
               count, out_valid, empty, gnt);
    end
`ifdef SFIFO_CTRL_ALMOST_FULL_EN
    n_checks++;
    if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_reset: got %b, expected 0", almost_full); end
`endif
    p0 = n_pop;
    drain(cyc);
    n_checks++;
    if (cyc >= 60 || (n_pop - p0) != 1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL post_reset_drain: cycles=%0d popped=%0d count=%0d, expected <60 1 0", cyc, n_pop - p0, count);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_output_order();
    test_fill_full();
    test_latency();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
